pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Fetch-side controller that drives the program counter's 2-bit control and load inputs and consumes the PC value.
- Issues instruction-memory reads at the current PC, holds each fetched word for the decoder on a valid/ready handshake, then steps the PC:
  - short step for a short instruction,
  - long step for a long instruction,
  - load for a taken branch.
- Sits between the PC, instruction memory and the decode stage.

Parameters:
- n, 4, PC/address width; must match the PC's n.
- w, 8, instruction word width; bit w-1 of a fetched word is the length flag.

Ports:
- clk  input  1  clock; all state changes on posedge
- clr  input  1  synchronous active-low reset; shared with the PC
- pc_in  input  n  current PC value (PC out)
- pc_cntrl  output  2  to PC cntrl: 00 hold, 01 load, 10 +1, 11 +inc
- pc_load  output  n  to PC loadIn; meaningful only when pc_cntrl=01
- mem_req  output  1  instruction read request
- mem_addr  output  n  read address; equals pc_in while mem_req=1
- mem_ack  input  1  one-cycle pulse; mem_data valid in the same cycle
- mem_data  input  w  fetched instruction word
- instr_valid  output  1  instr_data/instr_addr valid to decode
- instr_ready  input  1  decode accepts
- instr_data  output  w  registered fetched word
- instr_addr  output  n  PC of the held instruction
- br_valid  input  1  branch taken; sampled only on a handshake cycle
- br_target  input  n  branch destination
- halt  input  1  level; blocks the start of new fetches
- busy  output  1  1 in every state except IDLE

Behaviour:
- Reset:
  - clr=0 at a posedge forces state IDLE; instr_data/instr_addr are cleared to 0; any pending branch is cleared.
  - While clr=0 (and in IDLE afterwards): mem_req=0, instr_valid=0, pc_cntrl=00, pc_load=0, busy=0.
  - Reset mid-operation abandons any outstanding fetch. A mem_ack arriving after reset is ignored.
- All outputs are Moore (decoded from registered state and registers). No combinational path from input to output, except mem_addr=pc_in.
- IDLE:
  - halt=0 -> FETCH next cycle.
  - halt=1 -> stay in IDLE.
- FETCH:
  - mem_req=1, mem_addr=pc_in, busy=1.
  - Stays in FETCH until mem_ack=1.
  - On mem_ack: capture instr_data<=mem_data, instr_addr<=pc_in -> HOLD.
- HOLD:
  - instr_valid=1; instr_data and instr_addr are held stable until the handshake.
  - Handshake = instr_valid & instr_ready at a posedge -> ADVANCE.
  - On the handshake cycle, latch the step decision:
    - br_valid=1 -> step=LOAD, target<=br_target;
    - otherwise instr_data[w-1]=1 -> step=LONG;
    - otherwise step=SHORT.
  - br_valid outside the handshake cycle has no effect.
- ADVANCE (exactly one cycle):
  - pc_cntrl = 01 (LOAD, pc_load=target), 11 (LONG) or 10 (SHORT).
  - The PC updates at the end of this cycle.
  - Next state: halt=1 -> IDLE, else FETCH. The new fetch therefore sees the updated pc_in.
- pc_cntrl=00 in every state other than ADVANCE. Exactly one PC step occurs per delivered instruction.
- Latency, ack delay of A cycles after mem_req rises:
  - instr_valid rises A+1 cycles after FETCH entry.
  - With instr_ready held 1, the per-instruction period is A+3 cycles (minimum 3 with A=0, i.e. ack in the first FETCH cycle).
- Wrap-around: PC arithmetic is modulo 2^n and is performed in the PC. A step from all-ones wraps (e.g. n=4: 15 +1 -> 0, 15 +2 -> 1). The sequencer takes no special action.
- halt:
  - Does not interrupt FETCH or HOLD.
  - Is sampled only in IDLE and at ADVANCE exit.
- mem_ack outside FETCH is ignored.
- instr_ready outside HOLD is ignored.

Test Plan:
1. Reset, then halt=0, pc_in=0; mem_ack 2 cycles after mem_req with mem_data=0x12, instr_ready=1 -> mem_addr=0; instr_valid with instr_data=0x12, instr_addr=0; pc_cntrl=10 for exactly one cycle; next mem_addr=1.
2. Fetch at pc=3 returns mem_data=0x85 -> handshake yields pc_cntrl=11 for one cycle; next fetch at mem_addr=5 (PC inc=2).
3. On a handshake at pc=6, drive br_valid=1, br_target=9 -> pc_cntrl=01 with pc_load=9 for one cycle; next mem_addr=9. A br_valid pulse in FETCH changes nothing.
4. Backpressure: instr_ready=0 for 3 cycles after instr_valid -> instr_valid, instr_data and instr_addr stay stable; pc_cntrl stays 00; one step occurs only after instr_ready=1.
5. Assert clr=0 while in FETCH awaiting ack, then release and deliver a late mem_ack -> the late ack is ignored; all outputs return to reset values; a fresh fetch begins at the PC reset value 0.
6. halt=1 during HOLD -> instruction delivered and PC stepped once, then IDLE with busy=0 and mem_req=0; deassert halt -> FETCH resumes at the stepped address. At pc=15 (n=4), SHORT step -> next mem_addr=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side controller. Reads the instruction at the current PC,
// presents it to decode on a valid/ready handshake, then steps the PC once
// (short, long, or branch load) before starting the next fetch.
module pc_sequencer #(
    parameter int unsigned n = 4,
    parameter int unsigned w = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [n-1:0] pc_in,
    output logic [1:0]   pc_cntrl,
    output logic [n-1:0] pc_load,
    output logic         mem_req,
    output logic [n-1:0] mem_addr,
    input  logic         mem_ack,
    input  logic [w-1:0] mem_data,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [w-1:0] instr_data,
    output logic [n-1:0] instr_addr,
    input  logic         br_valid,
    input  logic [n-1:0] br_target,
    input  logic         halt,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        ADVANCE
    } state_t;

    // PC control encodings
    localparam logic [1:0] CNTRL_HOLD  = 2'b00;
    localparam logic [1:0] CNTRL_LOAD  = 2'b01;
    localparam logic [1:0] CNTRL_SHORT = 2'b10;
    localparam logic [1:0] CNTRL_LONG  = 2'b11;

    state_t       state_q;
    logic [1:0]   pc_cntrl_q;
    logic [n-1:0] pc_load_q;
    logic         mem_req_q;
    logic         instr_valid_q;
    logic [w-1:0] instr_data_q;
    logic [n-1:0] instr_addr_q;
    logic         busy_q;

    logic [1:0]   step_d;
    logic [n-1:0] load_d;

    // Step decision for the held instruction: a branch wins over the length flag
    always_comb begin
        step_d = CNTRL_SHORT;
        load_d = '0;
        if (br_valid) begin
            step_d = CNTRL_LOAD;
            load_d = br_target;
        end else if (instr_data_q[w-1]) begin
            step_d = CNTRL_LONG;
        end
    end

    // Sequencer FSM; every output is registered alongside the state it belongs to
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q       <= IDLE;
            pc_cntrl_q    <= CNTRL_HOLD;
            pc_load_q     <= '0;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            instr_addr_q  <= '0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!halt) begin
                        state_q   <= FETCH;
                        mem_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        state_q       <= HOLD;
                        instr_data_q  <= mem_data;
                        instr_addr_q  <= pc_in;
                        mem_req_q     <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        state_q       <= ADVANCE;
                        instr_valid_q <= 1'b0;
                        pc_cntrl_q    <= step_d;
                        pc_load_q     <= load_d;
                    end
                end
                ADVANCE: begin
                    pc_cntrl_q <= CNTRL_HOLD;
                    pc_load_q  <= '0;
                    if (halt) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q   <= FETCH;
                        mem_req_q <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    pc_cntrl_q    <= CNTRL_HOLD;
                    pc_load_q     <= '0;
                    mem_req_q     <= 1'b0;
                    instr_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign pc_cntrl    = pc_cntrl_q;
    assign pc_load     = pc_load_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = pc_in;
    assign instr_valid = instr_valid_q;
    assign instr_data  = instr_data_q;
    assign instr_addr  = instr_addr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a behavioural PC (increment 2 for long steps) and a
// directed instruction-memory responder around the DUT.
module tb_pc_sequencer;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic [N-1:0] pc_in;
    logic [1:0]   pc_cntrl;
    logic [N-1:0] pc_load;
    logic         mem_req;
    logic [N-1:0] mem_addr;
    logic         mem_ack = 1'b0;
    logic [W-1:0] mem_data = '0;
    logic         instr_valid;
    logic         instr_ready = 1'b0;
    logic [W-1:0] instr_data;
    logic [N-1:0] instr_addr;
    logic         br_valid = 1'b0;
    logic [N-1:0] br_target = '0;
    logic         halt = 1'b1;
    logic         busy;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.n(N), .w(W)) dut (
        .clk(clk), .clr(clr), .pc_in(pc_in), .pc_cntrl(pc_cntrl), .pc_load(pc_load),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
        .instr_addr(instr_addr), .br_valid(br_valid), .br_target(br_target),
        .halt(halt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Program counter: reset 0, load / +1 / +2, modulo 2^N
    logic [N-1:0] pc_q;
    always @(posedge clk) begin
        if (!clr) pc_q <= '0;
        else begin
            case (pc_cntrl)
                2'b01: pc_q <= pc_load;
                2'b10: pc_q <= pc_q + 4'd1;
                2'b11: pc_q <= pc_q + 4'd2;
                default: pc_q <= pc_q;
            endcase
        end
    end
    assign pc_in = pc_q;

    typedef struct {
        logic [W-1:0] data;
        int unsigned  delay;
        logic         br;
        logic [N-1:0] tgt;
        logic [N-1:0] addr;
        logic [1:0]   cntrl;
        logic [N-1:0] load;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && mem_req !== 1'b1; i++) @(negedge clk);
        check("mem_req_wait", {31'd0, mem_req}, 32'd1);
    endtask

    // One full instruction: fetch, deliver, handshake, step
    task automatic do_instr(input vec_t v);
        wait_req();
        check("mem_addr", {28'd0, mem_addr}, {28'd0, v.addr});
        check("busy_fetch", {31'd0, busy}, 32'd1);
        for (int unsigned i = 0; i < v.delay; i++) @(negedge clk);
        mem_ack  = 1'b1;
        mem_data = v.data;
        @(negedge clk);
        mem_ack  = 1'b0;
        check("instr_valid", {31'd0, instr_valid}, 32'd1);
        check("instr_data", {24'd0, instr_data}, {24'd0, v.data});
        check("instr_addr", {28'd0, instr_addr}, {28'd0, v.addr});
        check("cntrl_hold", {30'd0, pc_cntrl}, 32'd0);
        instr_ready = 1'b1;
        br_valid    = v.br;
        br_target   = v.tgt;
        @(negedge clk);
        instr_ready = 1'b0;
        br_valid    = 1'b0;
        check("cntrl_step", {30'd0, pc_cntrl}, {30'd0, v.cntrl});
        if (v.cntrl == 2'b01) check("pc_load", {28'd0, pc_load}, {28'd0, v.load});
        check("valid_adv", {31'd0, instr_valid}, 32'd0);
        check("req_adv", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        check("cntrl_after", {30'd0, pc_cntrl}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_cntrl"}, {30'd0, pc_cntrl}, 32'd0);
        check({tag, "_load"}, {28'd0, pc_load}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        //            data   dly br tgt addr cntrl load
        vecs[0] = '{8'h12, 2, 0, 0,  0,  2'b10, 0};
        vecs[1] = '{8'h05, 0, 0, 0,  1,  2'b10, 0};
        vecs[2] = '{8'h01, 1, 0, 0,  2,  2'b10, 0};
        vecs[3] = '{8'h85, 1, 0, 0,  3,  2'b11, 0};
        vecs[4] = '{8'h10, 0, 0, 0,  5,  2'b10, 0};
        vecs[5] = '{8'h85, 0, 1, 9,  6,  2'b01, 9};
        vecs[6] = '{8'hFF, 3, 0, 0,  9,  2'b11, 0};
        vecs[7] = '{8'h00, 0, 1, 14, 11, 2'b01, 14};
        vecs[8] = '{8'h80, 1, 0, 0,  14, 2'b11, 0};
        vecs[9] = '{8'h12, 0, 1, 15, 0,  2'b01, 15};

        // Reset
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        check("rst_data", {24'd0, instr_data}, 32'd0);
        check("rst_addr", {28'd0, instr_addr}, 32'd0);
        clr  = 1'b1;
        halt = 1'b0;

        foreach (vecs[i]) do_instr(vecs[i]);

        // halt raised during HOLD at pc=15: one short step wraps to 0, then IDLE
        wait_req();
        check("halt_addr", {28'd0, mem_addr}, 32'd15);
        mem_ack  = 1'b1;
        mem_data = 8'h01;
        @(negedge clk);
        mem_ack     = 1'b0;
        halt        = 1'b1;
        check("halt_valid", {31'd0, instr_valid}, 32'd1);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("halt_step", {30'd0, pc_cntrl}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs("halt_idle");
        end
        halt = 1'b0;
        @(negedge clk);
        check("resume_req", {31'd0, mem_req}, 32'd1);
        check("resume_addr", {28'd0, mem_addr}, 32'd0);

        // Stray br_valid / instr_ready in FETCH, then backpressure in HOLD
        br_valid    = 1'b1;
        br_target   = 4'd7;
        instr_ready = 1'b1;
        @(negedge clk);
        br_valid    = 1'b0;
        instr_ready = 1'b0;
        check("stray_req", {31'd0, mem_req}, 32'd1);
        check("stray_valid", {31'd0, instr_valid}, 32'd0);
        mem_ack  = 1'b1;
        mem_data = 8'h33;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", {31'd0, instr_valid}, 32'd1);
            check("bp_data", {24'd0, instr_data}, 32'h33);
            check("bp_addr", {28'd0, instr_addr}, 32'd0);
            check("bp_cntrl", {30'd0, pc_cntrl}, 32'd0);
            @(negedge clk);
        end
        check("bp_valid_last", {31'd0, instr_valid}, 32'd1);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("bp_step", {30'd0, pc_cntrl}, 32'd2);
        @(negedge clk);
        check("bp_cntrl_after", {30'd0, pc_cntrl}, 32'd0);
        check("bp_next_addr", {28'd0, mem_addr}, 32'd1);

        // Reset while FETCH awaits ack; late ack arrives while back in IDLE
        check("pre_rst_req", {31'd0, mem_req}, 32'd1);
        clr = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        check("midrst_data", {24'd0, instr_data}, 32'd0);
        check("midrst_addr", {28'd0, instr_addr}, 32'd0);
        clr      = 1'b1;
        mem_ack  = 1'b1;
        mem_data = 8'hAA;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_req", {31'd0, mem_req}, 32'd1);
        check("late_valid", {31'd0, instr_valid}, 32'd0);
        check("late_addr", {28'd0, mem_addr}, 32'd0);
        @(negedge clk);
        check("late_valid2", {31'd0, instr_valid}, 32'd0);
        do_instr('{8'h44, 1, 0, 0, 0, 2'b10, 0});
        check("final_addr", {28'd0, mem_addr}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
